// File: rtl/gcd_pkg.sv
// Shared types for the parametrised GCD unit: FSM state encoding and the
// A/B register mux selects driven by the controller into the datapath.
package gcd_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'b10,
        CALC = 2'b00,
        DONE = 2'b01
    } state_e;

    typedef enum logic [1:0] {
        A_SEL_HOLD = 2'd0,
        A_SEL_LOAD = 2'd1,
        A_SEL_B    = 2'd2,
        A_SEL_SUB  = 2'd3
    } a_sel_e;

    typedef enum logic [1:0] {
        B_SEL_HOLD = 2'd0,
        B_SEL_LOAD = 2'd1,
        B_SEL_A    = 2'd2,
        B_SEL_ZERO = 2'd3
    } b_sel_e;

endpackage

// File: rtl/gcd_unit_param_if.sv
// Operand/result handshake bundle for gcd_unit_param; the unit uses the
// slave modport, the requester/consumer side uses master.
interface gcd_unit_param_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic             operands_val;
    logic             operands_rdy;
    logic [WIDTH-1:0] operands_a;
    logic [WIDTH-1:0] operands_b;
    logic [TAG_W-1:0] operands_tag;
    logic             result_val;
    logic             result_rdy;
    logic [WIDTH-1:0] result_bits;
    logic [TAG_W-1:0] result_tag;
    logic             busy;

    modport slave (
        input  operands_val, operands_a, operands_b, operands_tag, result_rdy,
        output operands_rdy, result_val, result_bits, result_tag, busy
    );

    modport master (
        output operands_val, operands_a, operands_b, operands_tag, result_rdy,
        input  operands_rdy, result_val, result_bits, result_tag, busy
    );
endinterface

// File: rtl/gcd_datapath_param.sv
// GCD datapath: A/B/tag registers with their load muxes, the A-B subtractor
// and the A<B / B==0 flags consumed by the controller.
module gcd_datapath_param
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  a_sel_e           a_sel_i,
    input  b_sel_e           b_sel_i,
    input  logic             tag_ld_i,
    input  logic [WIDTH-1:0] ld_a_i,
    input  logic [WIDTH-1:0] ld_b_i,
    input  logic [TAG_W-1:0] ld_tag_i,
    output logic [WIDTH-1:0] a_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             a_lt_b_o,
    output logic             b_zero_o
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] diff;

    // Only ever evaluated into A when A >= B, so it cannot wrap.
    assign diff = a_q - b_q;

    always_comb begin
        a_d = a_q;
        case (a_sel_i)
            A_SEL_HOLD: a_d = a_q;
            A_SEL_LOAD: a_d = ld_a_i;
            A_SEL_B:    a_d = b_q;
            A_SEL_SUB:  a_d = diff;
            default:    a_d = a_q;
        endcase
    end

    always_comb begin
        b_d = b_q;
        case (b_sel_i)
            B_SEL_HOLD: b_d = b_q;
            B_SEL_LOAD: b_d = ld_b_i;
            B_SEL_A:    b_d = a_q;
            B_SEL_ZERO: b_d = '0;
            default:    b_d = b_q;
        endcase
    end

    always_comb begin
        tag_d = tag_q;
        if (tag_ld_i) begin
            tag_d = ld_tag_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            tag_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            tag_q <= tag_d;
        end
    end

    assign a_o      = a_q;
    assign tag_o    = tag_q;
    assign a_lt_b_o = (a_q < b_q);
    assign b_zero_o = (b_q == '0);

endmodule

// File: rtl/gcd_unit_param.sv
// Iterative subtract/swap GCD with tagged valid/ready request and result.
// Optional macro GCD_ZERO_SHORTCUT_EN resolves zero operands at accept time.
module gcd_unit_param
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    gcd_unit_param_if.slave io
);

    state_e           state_q, state_d;
    a_sel_e           a_sel;
    b_sel_e           b_sel;
    logic             tag_ld;
    logic [WIDTH-1:0] ld_a;
    logic [WIDTH-1:0] a_val;
    logic [TAG_W-1:0] tag_val;
    logic             a_lt_b;
    logic             b_zero;

    gcd_datapath_param #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) u_dpath (
        .clk      (clk),
        .reset    (reset),
        .a_sel_i  (a_sel),
        .b_sel_i  (b_sel),
        .tag_ld_i (tag_ld),
        .ld_a_i   (ld_a),
        .ld_b_i   (io.operands_b),
        .ld_tag_i (io.operands_tag),
        .a_o      (a_val),
        .tag_o    (tag_val),
        .a_lt_b_o (a_lt_b),
        .b_zero_o (b_zero)
    );

    always_comb begin
        state_d = state_q;
        a_sel   = A_SEL_HOLD;
        b_sel   = B_SEL_HOLD;
        tag_ld  = 1'b0;
        ld_a    = io.operands_a;
        case (state_q)
            IDLE: begin
                if (io.operands_val) begin
                    a_sel   = A_SEL_LOAD;
                    b_sel   = B_SEL_LOAD;
                    tag_ld  = 1'b1;
                    state_d = CALC;
`ifdef GCD_ZERO_SHORTCUT_EN
                    // A zero operand already fixes the answer: skip CALC.
                    if (io.operands_b == '0) begin
                        b_sel   = B_SEL_ZERO;
                        state_d = DONE;
                    end else if (io.operands_a == '0) begin
                        ld_a    = io.operands_b;
                        b_sel   = B_SEL_ZERO;
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                if (a_lt_b) begin
                    a_sel = A_SEL_B;
                    b_sel = B_SEL_A;
                end else if (!b_zero) begin
                    a_sel = A_SEL_SUB;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (io.result_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign io.operands_rdy = (state_q == IDLE);
    assign io.result_val   = (state_q == DONE);
    assign io.busy         = (state_q != IDLE);
    assign io.result_bits  = a_val;
    assign io.result_tag   = tag_val;

endmodule

// File: tb/tb_gcd_unit_param.sv
// Bench for gcd_unit_param: directed table and corner sequences on a 16-bit
// unit, plus randomized scoreboard runs on 8/16/32-bit units.
module tb_gcd_unit_param;

    localparam int NRAND  = 1000;
    localparam int BUDGET = 300;

`ifdef GCD_ZERO_SHORTCUT_EN
    localparam int LAT_B0 = 1;
    localparam int LAT_A0 = 1;
`else
    localparam int LAT_B0 = 2;
    localparam int LAT_A0 = 3;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rnd_reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    gcd_unit_param_if #(.WIDTH(16), .TAG_W(4)) bus ();
    gcd_unit_param #(.WIDTH(16), .TAG_W(4)) dut (.clk(clk), .reset(reset), .io(bus));

    function automatic longint unsigned ref_gcd(input longint unsigned a, input longint unsigned b);
        longint unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Randomized regression, one unit per width, each with its own scoreboard.
    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : 32;
        gcd_unit_param_if #(.WIDTH(W), .TAG_W(4)) rb ();
        gcd_unit_param #(.WIDTH(W), .TAG_W(4)) u_dut (.clk(clk), .reset(rnd_reset), .io(rb));
        logic [W-1:0] exp_res_q[$];
        logic [3:0]   exp_tag_q[$];
        bit           done_r = 1'b0;

        initial begin : drv
            longint unsigned maxg, gg, x, y, av, bv;
            int n;
            rb.operands_val = 1'b0;
            rb.operands_a   = '0;
            rb.operands_b   = '0;
            rb.operands_tag = '0;
            @(negedge clk);
            while (rnd_reset) @(negedge clk);
            maxg = ((64'd1 << W) - 1) / 15;
            for (int i = 0; i < NRAND; i++) begin
                @(negedge clk);
                gg = longint'($urandom_range(int'(maxg), 1));
                x  = longint'($urandom_range(15, 0));
                y  = longint'($urandom_range(15, 0));
                av = gg * x;
                bv = gg * y;
                rb.operands_a   = av[W-1:0];
                rb.operands_b   = bv[W-1:0];
                rb.operands_tag = 4'(i);
                rb.operands_val = 1'b1;
                n = 0;
                while (!rb.operands_rdy && n < BUDGET) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= BUDGET) begin
                    chk($sformatf("rand_accept_timeout_w%0d", W), 32'(n), 32'(0));
                    break;
                end
                exp_res_q.push_back(W'(ref_gcd(av, bv)));
                exp_tag_q.push_back(4'(i));
                @(posedge clk);
                #1 rb.operands_val = 1'b0;
            end
        end

        initial begin : mon
            int got;
            int idle;
            logic [W-1:0] er;
            logic [3:0]   et;
            got  = 0;
            idle = 0;
            rb.result_rdy = 1'b0;
            while (got < NRAND && idle < 2000) begin
                @(negedge clk);
                rb.result_rdy = ($urandom_range(3, 0) != 0);
                if (rb.result_val && rb.result_rdy) begin
                    if (exp_res_q.size() == 0) begin
                        chk($sformatf("rand_spurious_w%0d", W), 32'd1, 32'd0);
                    end else begin
                        er = exp_res_q.pop_front();
                        et = exp_tag_q.pop_front();
                        chk($sformatf("rand_res_w%0d_n%0d", W, got), 32'(rb.result_bits), 32'(er));
                        chk($sformatf("rand_tag_w%0d_n%0d", W, got), 32'(rb.result_tag), 32'(et));
                    end
                    got++;
                    idle = 0;
                end else begin
                    idle++;
                end
            end
            if (got < NRAND) chk($sformatf("rand_result_count_w%0d", W), 32'(got), 32'(NRAND));
            rb.result_rdy = 1'b0;
            done_r = 1'b1;
        end
    end

    // Issue a request on the directed unit; returns cycles from accept to result_val.
    task automatic run_req(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                           output int lat);
        @(negedge clk);
        chk("accept_rdy", 32'(bus.operands_rdy), 32'd1);
        bus.operands_a   = a;
        bus.operands_b   = b;
        bus.operands_tag = tag;
        bus.operands_val = 1'b1;
        @(posedge clk);
        #1 bus.operands_val = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.result_val && lat < BUDGET) begin
            chk("calc_rdy_low", 32'(bus.operands_rdy), 32'd0);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        bus.result_rdy = 1'b1;
        @(posedge clk);
        #1 bus.result_rdy = 1'b0;
        @(negedge clk);
        chk("post_result_val", 32'(bus.result_val), 32'd0);
        chk("post_result_rdy", 32'(bus.operands_rdy), 32'd1);
        chk("post_result_busy", 32'(bus.busy), 32'd0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
        logic [15:0] res;
        int          lat;
    } vec_t;

    initial begin : main
        vec_t vt[7];
        int   lat;
        int   seen;
        int   n;

        bus.operands_val = 1'b0;
        bus.operands_a   = '0;
        bus.operands_b   = '0;
        bus.operands_tag = '0;
        bus.result_rdy   = 1'b0;

        vt[0] = '{16'd15,    16'd5,     4'd3, 16'd5,     6};
        vt[1] = '{16'd7,     16'd0,     4'd1, 16'd7,     LAT_B0};
        vt[2] = '{16'd0,     16'd9,     4'd2, 16'd9,     LAT_A0};
        vt[3] = '{16'd0,     16'd0,     4'd4, 16'd0,     LAT_B0};
        vt[4] = '{16'd12,    16'd18,    4'd5, 16'd6,     8};
        vt[5] = '{16'd65535, 16'd65535, 4'd6, 16'd65535, 4};
        vt[6] = '{16'd21,    16'd14,    4'd7, 16'd7,     7};

        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b0;
        rnd_reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_rdy", 32'(bus.operands_rdy), 32'd1);
            chk("reset_val", 32'(bus.result_val), 32'd0);
            chk("reset_busy", 32'(bus.busy), 32'd0);
            chk("reset_bits", 32'(bus.result_bits), 32'd0);
            chk("reset_tag", 32'(bus.result_tag), 32'd0);
        end

        for (int i = 0; i < 7; i++) begin
            run_req(vt[i].a, vt[i].b, vt[i].tag, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("vec%0d_bits", i), 32'(bus.result_bits), 32'(vt[i].res));
            chk($sformatf("vec%0d_tag", i), 32'(bus.result_tag), 32'(vt[i].tag));
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'd1);
            chk($sformatf("vec%0d_rdy", i), 32'(bus.operands_rdy), 32'd0);
            consume();
        end

        // Backpressure in DONE with a competing request that must be ignored.
        run_req(16'd15, 16'd5, 4'd9, lat);
        chk("bp_latency", 32'(lat), 32'd6);
        for (int i = 0; i < 10; i++) begin
            bus.operands_a   = 16'd1;
            bus.operands_b   = 16'd1;
            bus.operands_tag = 4'd2;
            bus.operands_val = 1'b1;
            @(negedge clk);
            chk("bp_val", 32'(bus.result_val), 32'd1);
            chk("bp_bits", 32'(bus.result_bits), 32'd5);
            chk("bp_tag", 32'(bus.result_tag), 32'd9);
            chk("bp_rdy", 32'(bus.operands_rdy), 32'd0);
        end
        bus.operands_val = 1'b0;
        consume();
        run_req(16'd12, 16'd18, 4'd10, lat);
        chk("bp_next_bits", 32'(bus.result_bits), 32'd6);
        chk("bp_next_tag", 32'(bus.result_tag), 32'd10);
        consume();

        // Reset while a long computation is in flight.
        @(negedge clk);
        bus.operands_a   = 16'd65535;
        bus.operands_b   = 16'd1;
        bus.operands_tag = 4'd12;
        bus.operands_val = 1'b1;
        @(posedge clk);
        #1 bus.operands_val = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_rdy", 32'(bus.operands_rdy), 32'd1);
        chk("midrst_val", 32'(bus.result_val), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_bits", 32'(bus.result_bits), 32'd0);
        chk("midrst_tag", 32'(bus.result_tag), 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.result_val) seen++;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);
        run_req(16'd21, 16'd14, 4'd13, lat);
        chk("midrst_next_bits", 32'(bus.result_bits), 32'd7);
        chk("midrst_next_tag", 32'(bus.result_tag), 32'd13);
        consume();

        n = 0;
        while (!(g_rand[0].done_r && g_rand[1].done_r && g_rand[2].done_r) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60000) chk("rand_regression_timeout", 32'(n), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gcd_unit_param.md
Name: gcd_unit_param

Overview:
- Parametrised, self-contained iterative GCD unit: operand registers, subtract/swap datapath and control FSM in one block.
- Uses Euclid by repeated subtraction with swap.
- Operands in and result out both use valid/ready handshakes.
- Carries a user tag from operand to result so upstream logic can match responses.
- Drop-in successor to the fixed 16-bit GCD, for multi-width SoC use.

Parameters:
- WIDTH, 16: operand and result width in bits (>= 2).
- TAG_W, 4: width of the opaque tag carried with each request (>= 1).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- operands_val  in  1  request valid
- operands_rdy  out  1  unit can accept a request
- operands_a  in  WIDTH  operand A
- operands_b  in  WIDTH  operand B
- operands_tag  in  TAG_W  request tag
- result_val  out  1  result valid
- result_rdy  in  1  consumer ready
- result_bits  out  WIDTH  gcd(a,b)
- result_tag  out  TAG_W  tag of the request that produced this result
- busy  out  1  high in CALC or DONE

Behaviour:
- Registers: A, B (WIDTH), tag (TAG_W), state (2 bits). One clock; reset synchronous, active-high.
- Reset:
  - state=IDLE.
  - A, B and tag cleared to 0.
  - Outputs after reset: operands_rdy=1, result_val=0, busy=0, result_bits=0, result_tag=0.
- IDLE:
  - operands_rdy=1.
  - On operands_val&&operands_rdy: load A=a, B=b, tag=operands_tag; next state CALC.
- CALC, one step per cycle, priority order:
  - A<B (unsigned): swap A and B; stay in CALC.
  - else B!=0: A=A-B (WIDTH-bit unsigned; no underflow possible because A>=B); stay in CALC.
  - else (B==0): next state DONE; registers hold.
- DONE:
  - result_val=1, result_bits=A, result_tag=tag.
  - Outputs stay stable while result_rdy=0.
  - On result_rdy=1: next state IDLE.
- Latency:
  - Accept handshake in cycle t; first CALC cycle is t+1.
  - result_val first asserts one cycle after the CALC cycle that sees B==0.
- Throughput:
  - One request in flight.
  - operands_rdy=0 in CALC and DONE.
  - The result handshake and the next operand acceptance never occur in the same cycle: IDLE is always occupied for at least one cycle.
- Boundary cases:
  - gcd(0,0)=0.
  - gcd(x,0)=x.
  - gcd(0,x)=x (via one swap).
  - Max-value operands: no overflow, since subtraction only ever runs with A>=B.
- Reset mid-operation: in-flight request discarded, no result produced; reset values apply on the next cycle.
- result_val is never asserted outside DONE; operands_val is ignored outside IDLE.
- State encoding: IDLE=2'b10, CALC=2'b00, DONE=2'b01.
- Next-state logic and outputs are combinational from state, A, B; only the state and data registers are flops.

Optional Feature:
- Macro: GCD_ZERO_SHORTCUT_EN.
- When defined, the zero-operand checks are made on the operand inputs at the accept cycle:
  - b==0: load A=a, B=0 and go directly to DONE.
  - a==0 (and b!=0): load A=b, B=0 and go directly to DONE.
  - Result: result_val asserts in cycle t+1.
- When undefined: normal CALC path.
  - b==0: one CALC cycle.
  - a==0: swap cycle plus detect cycle.
- Results and tags are identical either way; only latency differs.

Decomposition:
- Package gcd_pkg:
  - state localparams IDLE/CALC/DONE and the state width;
  - A_mux_sel encodings (HOLD, LOAD, B, SUB);
  - B_mux_sel encodings (HOLD, LOAD, A, ZERO).
- Sub-module gcd_datapath_param (WIDTH, TAG_W):
  - contains the A/B/tag registers and muxes, the subtractor, and the A_lt_B / B_zero flags;
  - the top-level module holds the FSM and the handshakes.

Test Plan:
- Reset, then idle: operands_rdy=1, result_val=0, busy=0, result_bits=0 for 5 cycles.
- a=15, b=5, tag=3 accepted at t: 5 CALC cycles; result_val rises at t+6 with result_bits=5 and result_tag=3.
- a=7, b=0: without the macro, result_val at t+2 with result 7; with GCD_ZERO_SHORTCUT_EN, result_val at t+1 with result 7. Also check a=0, b=9 gives result 9 in both builds.
- Backpressure: hold result_rdy=0 for 10 cycles in DONE. result_bits, result_tag and result_val stay stable and operands_rdy stays 0. Release result_rdy, then accept the next request (a=12, b=18) the cycle after; result is 6.
- Reset mid-CALC: start a=65535, b=1 and assert reset 3 cycles later. Next cycle is IDLE with no result_val ever. A following request a=21, b=14 returns 7.
- Random regression: 1000 random pairs with WIDTH=8, 16, 32 and randomly toggled result_rdy. Compare results against a reference gcd and check that tag ordering is preserved.
